// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I-style datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// the datapath strobes from the current state, the opcode and the acks.
// Optional feature: define ILLEGAL_TRAP_EN to trap on unknown opcodes
// (sticky illegal flag, TRAP state left only by reset). Without it,
// unknown opcodes retire as NOPs and illegal is tied low.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_type,
    output logic        alu_src_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        OP_R      = 4'd0,
        OP_IALU   = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_JAL    = 4'd5,
        OP_JALR   = 4'd6,
        OP_LUI    = 4'd7,
        OP_AUIPC  = 4'd8,
        OP_BAD    = 4'd9
    } op_class_e;

    // Immediate format codes as seen by the immediate generator.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;
    localparam logic [2:0] IMM_R = 3'd6;

    state_e    state_q;
    state_e    state_d;
    op_class_e op_class;
    logic [2:0] imm_sel;
    logic       unused_instr_bits;

    // Only the opcode field steers control; the rest belongs to the datapath.
    assign unused_instr_bits = ^instr[31:7];

    // Classify the opcode and pick its immediate format.
    always_comb begin
        op_class = OP_BAD;
        imm_sel  = IMM_R;
        case (instr[6:0])
            7'b0110011: begin op_class = OP_R;      imm_sel = IMM_R; end
            7'b0010011: begin op_class = OP_IALU;   imm_sel = IMM_I; end
            7'b0000011: begin op_class = OP_LOAD;   imm_sel = IMM_I; end
            7'b0100011: begin op_class = OP_STORE;  imm_sel = IMM_S; end
            7'b1100011: begin op_class = OP_BRANCH; imm_sel = IMM_B; end
            7'b1101111: begin op_class = OP_JAL;    imm_sel = IMM_J; end
            7'b1100111: begin op_class = OP_JALR;   imm_sel = IMM_I; end
            7'b0110111: begin op_class = OP_LUI;    imm_sel = IMM_U; end
            7'b0010111: begin op_class = OP_AUIPC;  imm_sel = IMM_U; end
            default:    begin op_class = OP_BAD;    imm_sel = IMM_R; end
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // State register; reset wins over any in-flight fetch or memory access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; every output defaults to idle values.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        imm_type  = IMM_R;
        alu_src_b = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = 2'd0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                imm_type = imm_sel;
                if (op_class != OP_BAD) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                imm_type  = imm_sel;
                alu_src_b = !((op_class == OP_R) || (op_class == OP_BRANCH));
                case (op_class)
                    OP_LOAD, OP_STORE: begin
                        state_d = S_MEM;
                    end
                    OP_BRANCH: begin
                        pc_we   = branch_taken;
                        pc_src  = 2'd1;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd1;
                        state_d = S_WB;
                    end
                    OP_JALR: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        state_d = S_WB;
                    end
                    default: begin
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                imm_type = imm_sel;
                dmem_req = 1'b1;
                dmem_we  = (op_class == OP_STORE);
                if (dmem_ack) begin
                    state_d = (op_class == OP_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                imm_type = imm_sel;
                rf_we    = 1'b1;
                if (op_class == OP_LOAD) begin
                    wb_sel = 2'd1;
                end else if ((op_class == OP_JAL) || (op_class == OP_JALR)) begin
                    wb_sel = 2'd2;
                end else begin
                    wb_sel = 2'd0;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The unused encoding 7 is reported as IDLE, matching how it behaves.
    assign state = (state_q == 3'd7) ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// Inputs change on the falling edge, outputs are checked 1 ns later.
// Expectations for the unknown-opcode case follow ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_ack;
    logic        dmem_ack;
    logic        branch_taken;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  imm_type;
    logic        alu_src_b;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_LW   = 32'h0000A503;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_JAL  = 32'h0080006F;
    localparam logic [31:0] I_JALR = 32'h00008067;
    localparam logic [31:0] I_LUI  = 32'h000012B7;

    multicycle_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .imm_type     (imm_type),
        .alu_src_b    (alu_src_b),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .illegal      (illegal)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait for the next falling edge, then drive all inputs.
    task automatic applyStimulus(input logic r, input logic [31:0] ins,
                                 input logic ia, input logic da, input logic bt);
        @(negedge clk);
        rst_n        = r;
        instr        = ins;
        imem_ack     = ia;
        dmem_ack     = da;
        branch_taken = bt;
        #1;
    endtask

    // Compare every output at once, packed as
    // {state,imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_src,imm_type,alu_src_b,rf_we,wb_sel,illegal}.
    task automatic checkOutput(input string tag, input logic [2:0] e_st,
                               input logic e_ireq, input logic e_dreq, input logic e_dwe,
                               input logic e_irwe, input logic e_pcwe, input logic [1:0] e_pcsrc,
                               input logic [2:0] e_imm, input logic e_alub, input logic e_rfwe,
                               input logic [1:0] e_wbsel, input logic e_ill);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
               imm_type, alu_src_b, rf_we, wb_sel, illegal};
        exp = {e_st, e_ireq, e_dreq, e_dwe, e_irwe, e_pcwe, e_pcsrc,
               e_imm, e_alub, e_rfwe, e_wbsel, e_ill};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'h0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then release with imem_ack held high.
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("reset",        0, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_ADD, 1, 0, 0);
        checkOutput("idle_one",     0, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_ADD, 1, 0, 0);
        checkOutput("fetch_ack",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);

        // add: DECODE, EXEC, WB, back to FETCH.
        applyStimulus(1, I_ADD, 0, 0, 0);
        checkOutput("add_dec",      2, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_ADD, 0, 0, 0);
        checkOutput("add_exec",     3, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_ADD, 0, 0, 0);
        checkOutput("add_wb",       5, 0,0,0,0,0, 0, 6, 0,1, 0, 0);

        // FETCH without imem_ack waits; a stray dmem_ack is ignored.
        applyStimulus(1, I_ADD, 0, 1, 0);
        checkOutput("fetch_wait",   1, 1,0,0,0,0, 0, 6, 0,0, 0, 0);

        // lw with dmem_ack delayed three cycles.
        applyStimulus(1, I_LW, 1, 0, 0);
        checkOutput("lw_fetch",     1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 0, 0);
        checkOutput("lw_dec",       2, 0,0,0,0,0, 0, 0, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 0, 0);
        checkOutput("lw_exec",      3, 0,0,0,0,0, 0, 0, 1,0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, I_LW, 0, 0, 0);
            checkOutput("lw_mem_wait", 4, 0,1,0,0,0, 0, 0, 0,0, 0, 0);
        end
        applyStimulus(1, I_LW, 0, 1, 0);
        checkOutput("lw_mem_ack",   4, 0,1,0,0,0, 0, 0, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 0, 0);
        checkOutput("lw_wb",        5, 0,0,0,0,0, 0, 0, 0,1, 1, 0);

        // beq taken, then not taken.
        applyStimulus(1, I_BEQ, 1, 0, 1);
        checkOutput("beq_fetch",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_BEQ, 0, 0, 1);
        checkOutput("beq_dec",      2, 0,0,0,0,0, 0, 3, 0,0, 0, 0);
        applyStimulus(1, I_BEQ, 0, 0, 1);
        checkOutput("beq_taken",    3, 0,0,0,0,1, 1, 3, 0,0, 0, 0);
        applyStimulus(1, I_BEQ, 1, 0, 0);
        checkOutput("beq2_fetch",   1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_BEQ, 0, 0, 0);
        checkOutput("beq2_dec",     2, 0,0,0,0,0, 0, 3, 0,0, 0, 0);
        applyStimulus(1, I_BEQ, 0, 0, 0);
        checkOutput("beq_not",      3, 0,0,0,0,0, 1, 3, 0,0, 0, 0);

        // Unknown opcode.
        applyStimulus(1, I_BAD, 1, 0, 0);
        checkOutput("bad_fetch",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_BAD, 0, 0, 0);
        checkOutput("bad_dec",      2, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_BAD, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        checkOutput("bad_trap",     6, 0,0,0,0,0, 0, 6, 0,0, 0, 1);
        applyStimulus(0, I_BAD, 1, 0, 0);
        checkOutput("bad_trap_hold",6, 0,0,0,0,0, 0, 6, 0,0, 0, 1);
`else
        checkOutput("bad_nop",      1, 1,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(0, I_BAD, 0, 0, 0);
        checkOutput("bad_nop_wait", 1, 1,0,0,0,0, 0, 6, 0,0, 0, 0);
`endif
        applyStimulus(1, I_SW, 1, 0, 0);
        checkOutput("bad_reset",    0, 0,0,0,0,0, 0, 6, 0,0, 0, 0);

        // sw: MEM with dmem_we, ack returns straight to FETCH.
        applyStimulus(1, I_SW, 1, 0, 0);
        checkOutput("sw_fetch",     1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_SW, 0, 0, 0);
        checkOutput("sw_dec",       2, 0,0,0,0,0, 0, 2, 0,0, 0, 0);
        applyStimulus(1, I_SW, 0, 0, 0);
        checkOutput("sw_exec",      3, 0,0,0,0,0, 0, 2, 1,0, 0, 0);
        applyStimulus(1, I_SW, 0, 1, 0);
        checkOutput("sw_mem",       4, 0,1,1,0,0, 0, 2, 0,0, 0, 0);

        // lw interrupted by reset in MEM; the late ack must be ignored.
        applyStimulus(1, I_LW, 1, 0, 0);
        checkOutput("lw2_fetch",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 0, 0);
        checkOutput("lw2_dec",      2, 0,0,0,0,0, 0, 0, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 0, 0);
        checkOutput("lw2_exec",     3, 0,0,0,0,0, 0, 0, 1,0, 0, 0);
        applyStimulus(0, I_LW, 0, 0, 0);
        checkOutput("lw2_mem",      4, 0,1,0,0,0, 0, 0, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 1, 0);
        checkOutput("mem_reset",    0, 0,0,0,0,0, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_LW, 0, 1, 0);
        checkOutput("late_ack",     1, 1,0,0,0,0, 0, 6, 0,0, 0, 0);

        // jal.
        applyStimulus(1, I_JAL, 1, 0, 0);
        checkOutput("jal_fetch",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_JAL, 0, 0, 0);
        checkOutput("jal_dec",      2, 0,0,0,0,0, 0, 5, 0,0, 0, 0);
        applyStimulus(1, I_JAL, 0, 0, 0);
        checkOutput("jal_exec",     3, 0,0,0,0,1, 1, 5, 1,0, 0, 0);
        applyStimulus(1, I_JAL, 0, 0, 0);
        checkOutput("jal_wb",       5, 0,0,0,0,0, 0, 5, 0,1, 2, 0);

        // jalr.
        applyStimulus(1, I_JALR, 1, 0, 0);
        checkOutput("jalr_fetch",   1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_JALR, 0, 0, 0);
        checkOutput("jalr_dec",     2, 0,0,0,0,0, 0, 0, 0,0, 0, 0);
        applyStimulus(1, I_JALR, 0, 0, 0);
        checkOutput("jalr_exec",    3, 0,0,0,0,1, 2, 0, 1,0, 0, 0);
        applyStimulus(1, I_JALR, 0, 0, 0);
        checkOutput("jalr_wb",      5, 0,0,0,0,0, 0, 0, 0,1, 2, 0);

        // lui.
        applyStimulus(1, I_LUI, 1, 0, 0);
        checkOutput("lui_fetch",    1, 1,0,0,1,1, 0, 6, 0,0, 0, 0);
        applyStimulus(1, I_LUI, 0, 0, 0);
        checkOutput("lui_dec",      2, 0,0,0,0,0, 0, 4, 0,0, 0, 0);
        applyStimulus(1, I_LUI, 0, 0, 0);
        checkOutput("lui_exec",     3, 0,0,0,0,0, 0, 4, 1,0, 0, 0);
        applyStimulus(1, I_LUI, 0, 0, 0);
        checkOutput("lui_wb",       5, 0,0,0,0,0, 0, 4, 0,1, 0, 0);
        applyStimulus(1, I_LUI, 0, 0, 0);
        checkOutput("lui_next",     1, 1,0,0,0,0, 0, 6, 0,0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have ports: instr  in  32  current instruction-register contents; imem_ack  in  1  fetch complete; dmem_ack  in  1  data access complete; branch_taken  in  1  ALU compare result.
REQ-004 The block SHALL have ports: imem_req  out  1; dmem_req  out  1; dmem_we  out  1 (store); ir_we  out  1 (load instruction register).
REQ-005 The block SHALL have ports: pc_we  out  1; pc_src  out  2 (0 PC+4, 1 PC-relative target, 2 rs1+imm).
REQ-006 The block SHALL have ports: imm_type  out  3 (I=0, S=2, B=3, U=4, J=5, R=6).
REQ-007 The block SHALL have ports: alu_src_b  out  1 (1=imm); rf_we  out  1; wb_sel  out  2 (0 ALU, 1 memory, 2 PC+4).
REQ-008 The block SHALL have ports: state  out  3 (current state); illegal  out  1 (sticky illegal-opcode flag).

Function
REQ-009 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; value 7 is unreachable and SHALL decode to IDLE.
REQ-010 IDLE: all strobes 0; unconditional transition to FETCH next cycle.
REQ-011 FETCH: imem_req=1 held until imem_ack=1; in the ack cycle ir_we=1, pc_we=1, pc_src=0, next state DECODE; no ack means stay, strobes ir_we/pc_we 0.
REQ-012 The datapath retains the pre-increment PC; targets for pc_src 1 use that value.
REQ-013 DECODE: opcode = instr[6:0]; one cycle, next EXEC for legal opcodes (0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc).
REQ-014 imm_type SHALL be driven from opcode in DECODE through WB: R-type 6, I-ALU/load/jalr 0, store 2, branch 3, lui/auipc 4, jal 5; 6 in all other states and for unknown opcodes.
REQ-015 alu_src_b SHALL be 0 for R-type and branch, 1 otherwise, valid in EXEC.
REQ-016 EXEC: load/store -> MEM; branch -> FETCH with pc_we=branch_taken, pc_src=1; jal -> WB with pc_we=1, pc_src=1; jalr -> WB with pc_we=1, pc_src=2; all others -> WB.
REQ-017 MEM: dmem_req=1, dmem_we=1 for store; held until dmem_ack; on ack load -> WB, store -> FETCH.
REQ-018 WB: rf_we=1 for exactly one cycle; wb_sel=1 for load, 2 for jal/jalr, 0 otherwise; next FETCH.
REQ-019 Latency with single-cycle acks: branch 3, R/I/U/store/jal/jalr 4, load 5 cycles from FETCH entry to next FETCH entry.
REQ-020 imem_req and dmem_req SHALL never be asserted in the same cycle; req deasserts the cycle after ack.
REQ-021 Acks arriving outside FETCH/MEM SHALL be ignored.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force state=IDLE and illegal=0 regardless of current state, including mid-fetch or mid-memory access.
REQ-023 In IDLE (and hence after reset) all outputs SHALL be 0 except imm_type=6.
REQ-024 An outstanding ack received after reset SHALL be ignored per REQ-021.

Configuration
REQ-025 Macro ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> TRAP; TRAP holds all strobes 0, illegal=1, exits only by reset.
REQ-026 Macro ILLEGAL_TRAP_EN undefined: unknown opcode in DECODE -> FETCH (NOP, no writes); illegal tied 0; TRAP unreachable.

Verification
REQ-027 Reset release, imem_ack=1 constant -> IDLE 1 cycle, FETCH with imem_req=1, ir_we=1, pc_we=1.
REQ-028 instr=0x00B50533 (add), acks immediate -> states 1,2,3,5,1; imm_type=6; rf_we=1 once, wb_sel=0.
REQ-029 instr=0x0000A503 (lw), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB with wb_sel=1, imm_type=0.
REQ-030 instr=0x00208463 (beq), branch_taken=1 then 0 on repeat -> EXEC pc_we=1 pc_src=1 imm_type=3; then pc_we=0; no rf_we.
REQ-031 instr=0x0000007F: with ILLEGAL_TRAP_EN -> state 6, illegal=1 until rst_n=0; without -> back to FETCH, illegal=0.
REQ-032 rst_n=0 during MEM with dmem_req=1 -> next cycle state=0, dmem_req=0; late dmem_ack ignored.
